// File: rtl/seq_detector_param_if.sv
// ----------------------------------------------------------------------------
// seq_detector_param_if
//   Bundles the serial-detector control/data signals into one port.
//   master : drives en, in, load, pat_in, clr_cnt; observes q, match_cnt, sat
//   slave  : the detector side (inverse directions)
//   Parameters N (pattern length) and CNT_W (match counter width) must match
//   the detector instance this interface is bound to.
// ----------------------------------------------------------------------------
interface seq_detector_param_if #(
  parameter int N     = 6,
  parameter int CNT_W = 8
);
  logic             en;         // sample enable
  logic             in;         // serial data bit
  logic             load;       // load a new pattern from pat_in
  logic [N-1:0]     pat_in;     // new pattern, MSB = first bit received
  logic             clr_cnt;    // synchronous clear of match_cnt
  logic             q;          // registered Moore match flag
  logic [CNT_W-1:0] match_cnt;  // saturating match counter
  logic             sat;        // match_cnt is all-ones

  modport master (
    output en, in, load, pat_in, clr_cnt,
    input  q, match_cnt, sat
  );

  modport slave (
    input  en, in, load, pat_in, clr_cnt,
    output q, match_cnt, sat
  );
endinterface

// File: rtl/seq_detector_param.sv
// ----------------------------------------------------------------------------
// seq_detector_param
//   Parametrised Moore serial-pattern detector with run-time reloadable
//   pattern, overlapping / non-overlapping match mode, input-enable
//   qualification and a saturating match counter.
//
//   Ports:
//     clk  : single clock, all state updates on the rising edge
//     rst  : asynchronous active-low reset
//     bus  : seq_detector_param_if.slave
//            en, in, load, pat_in, clr_cnt in; q, match_cnt, sat out
//
//   Parameters:
//     N       : pattern length, 2..32
//     PATTERN : reset-time pattern, MSB = first bit received
//     OVERLAP : 1 = matches may share bits, 0 = N fresh bits after a match
//     CNT_W   : match counter width, 1..32
// ----------------------------------------------------------------------------
module seq_detector_param #(
  parameter int           N       = 6,
  parameter logic [N-1:0] PATTERN = 6'b011010,
  parameter bit           OVERLAP = 1'b1,
  parameter int           CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  seq_detector_param_if.slave  bus
);

  // fill counts 0..N inclusive, so it needs room for the value N itself.
  localparam int             FW   = $clog2(N + 1);
  localparam logic [FW-1:0]  FULL = FW'(N);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-1:0]     pat_r,  pat_n;
  logic [N-1:0]     hist_r, hist_n;
  logic [FW-1:0]    fill_r, fill_n;
  logic             mflag_r, mflag_n;
  logic [CNT_W-1:0] cnt_r,  cnt_n;

  logic [FW-1:0]    fill_inc;
  logic             match;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value before any branch, so no path
    // through this block leaves one unassigned and no latch is inferred.
    pat_n    = pat_r;
    hist_n   = hist_r;
    fill_n   = fill_r;
    mflag_n  = mflag_r;
    cnt_n    = cnt_r;
    match    = 1'b0;
    fill_inc = (fill_r == FULL) ? FULL : fill_r + FW'(1);

    if (bus.load) begin
      // A reload discards any partially matched history; the counter keeps
      // its value and en/in are ignored on this edge.
      pat_n   = bus.pat_in;
      hist_n  = '0;
      fill_n  = '0;
      mflag_n = 1'b0;
    end else if (bus.en) begin
      hist_n  = {hist_r[N-2:0], bus.in};
      // Compare against the post-shift history and post-increment fill, so
      // the bit completing the pattern is recognised on the edge it arrives.
      match   = (hist_n == pat_r) && (fill_inc == FULL);
      mflag_n = match;
      // Non-overlapping mode empties the history count so the matched bits
      // cannot contribute to the next match.
      fill_n  = (match && !OVERLAP) ? '0 : fill_inc;
    end

    // Clear wins over the increment, but a match on the clearing edge still
    // counts as the first match of the new epoch.
    if (bus.clr_cnt) begin
      cnt_n = match ? CNT_W'(1) : '0;
    end else if (match && (cnt_r != CNT_MAX)) begin
      cnt_n = cnt_r + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_r   <= PATTERN;
      hist_r  <= '0;
      fill_r  <= '0;
      mflag_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values computed above, independent of statement order.
      pat_r   <= pat_n;
      hist_r  <= hist_n;
      fill_r  <= fill_n;
      mflag_r <= mflag_n;
      cnt_r   <= cnt_n;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: q comes straight from a register, no path from in.
  // --------------------------------------------------------------------------
  assign bus.q         = mflag_r;
  assign bus.match_cnt = cnt_r;
  assign bus.sat       = &cnt_r;

endmodule
